div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq_if.sv | 23 ++
 rtl/div_seq.sv | 107 ++++++++++
 tb/tb_div_seq.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_seq_if.sv
// Operand, control and result signals between the EX stage and the sequential divider.
// No latency of its own: it carries only wires.
// The divider holds busy_o while it computes; EX holds start_i until it takes the result.
interface div_seq_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, busy_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, busy_o
    );
endinterface

// File: rtl/div_seq.sv
// 32-bit signed/unsigned restoring divider; result is {remainder, quotient}.
// ready_o rises 34 edges after start_i is sampled (2 edges for a zero divisor).
// busy_o stalls EX while computing; the result is held while start_i stays high.
module div_seq (
    input  logic      clk,
    input  logic      rst,
    div_seq_if.slave  bus
);
    localparam logic [1:0] S_FREE   = 2'b00;
    localparam logic [1:0] S_BYZERO = 2'b01;
    localparam logic [1:0] S_ON     = 2'b10;
    localparam logic [1:0] S_END    = 2'b11;

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [64:0] work;
    logic [31:0] divisor_abs;
    logic        signed_q;
    logic        sign1;
    logic        sign2;

    logic [31:0] op1_abs;
    logic [31:0] op2_abs;
    logic [32:0] diff;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    // Magnitudes are taken from the live inputs; they only matter on the edge leaving FREE.
    assign op1_abs = (bus.signed_div_i && bus.opdata1_i[31]) ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
    assign op2_abs = (bus.signed_div_i && bus.opdata2_i[31]) ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;

    assign diff = work[64:32] - {1'b0, divisor_abs};

    assign quot_fix = (signed_q && (sign1 ^ sign2)) ? (~work[31:0] + 32'd1) : work[31:0];
    assign rem_fix  = (signed_q && sign1) ? (~work[64:33] + 32'd1) : work[64:33];

    assign bus.busy_o = (state == S_BYZERO) || (state == S_ON);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_FREE;
            cnt          <= 6'd0;
            work         <= 65'd0;
            divisor_abs  <= 32'd0;
            signed_q     <= 1'b0;
            sign1        <= 1'b0;
            sign2        <= 1'b0;
            bus.result_o <= 64'd0;
            bus.ready_o  <= 1'b0;
        end else begin
            case (state)
                S_FREE: begin
                    bus.ready_o  <= 1'b0;
                    bus.result_o <= 64'd0;
                    if (bus.start_i && !bus.annul_i) begin
                        signed_q    <= bus.signed_div_i;
                        sign1       <= bus.opdata1_i[31];
                        sign2       <= bus.opdata2_i[31];
                        divisor_abs <= op2_abs;
                        work        <= {32'd0, op1_abs, 1'b0};
                        cnt         <= 6'd0;
                        state       <= (bus.opdata2_i == 32'd0) ? S_BYZERO : S_ON;
                    end
                end
                S_BYZERO: begin
                    bus.result_o <= 64'd0;
                    cnt          <= 6'd0;
                    if (bus.annul_i) begin
                        bus.ready_o <= 1'b0;
                        state       <= S_FREE;
                    end else begin
                        bus.ready_o <= 1'b1;
                        state       <= S_END;
                    end
                end
                S_ON: begin
                    if (bus.annul_i) begin
                        bus.ready_o  <= 1'b0;
                        bus.result_o <= 64'd0;
                        cnt          <= 6'd0;
                        state        <= S_FREE;
                    end else if (cnt != 6'd32) begin
                        // Negative trial difference: keep the partial remainder, quotient bit 0.
                        if (diff[32]) begin
                            work <= {work[63:0], 1'b0};
                        end else begin
                            work <= {diff[31:0], work[31:0], 1'b1};
                        end
                        cnt <= cnt + 6'd1;
                    end else begin
                        bus.result_o <= {rem_fix, quot_fix};
                        bus.ready_o  <= 1'b1;
                        cnt          <= 6'd0;
                        state        <= S_END;
                    end
                end
                S_END: begin
                    if (!bus.start_i) begin
                        bus.ready_o  <= 1'b0;
                        bus.result_o <= 64'd0;
                        state        <= S_FREE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases plus random operands
// compared against an arithmetic reference model.
module tb_div_seq;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    div_seq_if bus ();

    div_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: truncating division on magnitudes, quotient sign = xor of signs,
    // remainder takes the dividend's sign; divide by zero yields all zeros.
    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ua, ub, q, r;
        if (b == 32'd0) return 64'd0;
        if (!s) return {a % b, a / b};
        ua = a[31] ? (32'd0 - a) : a;
        ub = b[31] ? (32'd0 - b) : b;
        q  = ua / ub;
        r  = ua % ub;
        if (a[31] != b[31]) q = 32'd0 - q;
        if (a[31]) r = 32'd0 - r;
        return {r, q};
    endfunction

    // Raises start_i and counts edges until ready_o; scrambles operand inputs after
    // the first edge so a design that fails to latch them produces a wrong answer.
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           output int edges, output logic [63:0] res,
                           output logic busy_ok, output logic zero_ok);
        bus.signed_div_i = s;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        edges   = 0;
        busy_ok = 1'b1;
        zero_ok = 1'b1;
        while (edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            bus.opdata1_i    = $urandom;
            bus.opdata2_i    = $urandom;
            bus.signed_div_i = 1'($urandom_range(0, 1));
            if (bus.ready_o) break;
            if (!bus.busy_o) busy_ok = 1'b0;
            if (bus.result_o != 64'd0) zero_ok = 1'b0;
        end
        res = bus.result_o;
    endtask

    task automatic drop_start;
        bus.start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start_i = 1'b1;
        bus.annul_i = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i = 32'd5;
        bus.opdata2_i = 32'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bus.ready_o); end
        checks++;
        if (bus.result_o !== 64'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", bus.result_o); end
        checks++;
        if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
        bus.start_i = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_unsigned_basic;
        int e; logic [63:0] r; logic bo, zo;
        run_div(1'b0, 32'd100, 32'd7, e, r, bo, zo);
        checks++;
        if (e !== 34) begin errors++; $display("FAIL u100_7_latency got=%0d exp=34", e); end
        checks++;
        if (r !== 64'h00000002_0000000E) begin errors++; $display("FAIL u100_7_result got=%h exp=%h", r, 64'h00000002_0000000E); end
        checks++;
        if (bo !== 1'b1) begin errors++; $display("FAIL u100_7_busy got=%b exp=1", bo); end
        checks++;
        if (zo !== 1'b1) begin errors++; $display("FAIL u100_7_result_zero_while_busy got=%b exp=1", zo); end
        checks++;
        if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL u100_7_busy_end got=%b exp=0", bus.busy_o); end
        drop_start();
    endtask

    task automatic test_signed;
        int e; logic [63:0] r; logic bo, zo;
        run_div(1'b1, 32'hFFFFFFF9, 32'h00000002, e, r, bo, zo);
        checks++;
        if (r !== 64'hFFFFFFFF_FFFFFFFD || e !== 34) begin
            errors++; $display("FAIL s_m7_2 got=%h edges=%0d exp=%h edges=34", r, e, 64'hFFFFFFFF_FFFFFFFD);
        end
        drop_start();
        run_div(1'b1, 32'h00000007, 32'hFFFFFFFE, e, r, bo, zo);
        checks++;
        if (r !== 64'h00000001_FFFFFFFD || e !== 34) begin
            errors++; $display("FAIL s_7_m2 got=%h edges=%0d exp=%h edges=34", r, e, 64'h00000001_FFFFFFFD);
        end
        drop_start();
        run_div(1'b0, 32'hFFFFFFF9, 32'h00000002, e, r, bo, zo);
        checks++;
        if (r !== 64'h00000001_7FFFFFFC) begin
            errors++; $display("FAIL u_big_2 got=%h exp=%h", r, 64'h00000001_7FFFFFFC);
        end
        drop_start();
    endtask

    task automatic test_div_zero;
        int e; logic [63:0] r; logic bo, zo;
        logic [31:0] dividends [2];
        dividends[0] = 32'h12345678;
        dividends[1] = 32'h80000000;
        for (int i = 0; i < 2; i++) begin
            run_div(1'(i), dividends[i], 32'd0, e, r, bo, zo);
            checks++;
            if (e !== 2) begin errors++; $display("FAIL divzero_latency[%0d] got=%0d exp=2", i, e); end
            checks++;
            if (r !== 64'd0) begin errors++; $display("FAIL divzero_result[%0d] got=%h exp=0", i, r); end
            checks++;
            if (bo !== 1'b1) begin errors++; $display("FAIL divzero_busy[%0d] got=%b exp=1", i, bo); end
            drop_start();
        end
    endtask

    task automatic test_annul;
        int e; logic [63:0] r; logic bo, zo;
        logic saw_ready;
        saw_ready = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i = 32'd100;
        bus.opdata2_i = 32'd7;
        bus.start_i = 1'b1;
        repeat (11) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.ready_o) saw_ready = 1'b1;
        end
        bus.annul_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (bus.ready_o) saw_ready = 1'b1;
        checks++;
        if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL annul_on_busy got=%b exp=0", bus.busy_o); end
        checks++;
        if (bus.result_o !== 64'd0) begin errors++; $display("FAIL annul_on_result got=%h exp=0", bus.result_o); end
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.ready_o) saw_ready = 1'b1;
        end
        checks++;
        if (saw_ready !== 1'b0) begin errors++; $display("FAIL annul_on_ready got=%b exp=0", saw_ready); end

        run_div(1'b0, 32'd9, 32'd3, e, r, bo, zo);
        checks++;
        if (r !== 64'h00000000_00000003 || e !== 34) begin
            errors++; $display("FAIL annul_then_9_3 got=%h edges=%0d exp=%h edges=34", r, e, 64'h3);
        end
        drop_start();

        bus.opdata2_i = 32'd0;
        bus.start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.ready_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            errors++; $display("FAIL annul_byzero ready=%b busy=%b exp ready=0 busy=0", bus.ready_o, bus.busy_o);
        end
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_end_hold;
        int e; logic [63:0] r; logic bo, zo;
        logic stable;
        stable = 1'b1;
        run_div(1'b1, 32'hFFFF0000, 32'd12345, e, r, bo, zo);
        checks++;
        if (r !== model(1'b1, 32'hFFFF0000, 32'd12345)) begin
            errors++; $display("FAIL hold_result got=%h exp=%h", r, model(1'b1, 32'hFFFF0000, 32'd12345));
        end
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.ready_o !== 1'b1 || bus.result_o !== r) stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) begin errors++; $display("FAIL hold_stable got=%b exp=1", stable); end
        drop_start();
        checks++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
            errors++; $display("FAIL hold_release ready=%b result=%h exp ready=0 result=0", bus.ready_o, bus.result_o);
        end
    endtask

    task automatic test_reset_mid_on;
        int e; logic [63:0] r; logic bo, zo;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i = 32'hDEADBEEF;
        bus.opdata2_i = 32'd3;
        bus.start_i = 1'b1;
        repeat (21) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0 || bus.busy_o !== 1'b0) begin
            errors++; $display("FAIL rst_mid_on ready=%b result=%h busy=%b exp all 0", bus.ready_o, bus.result_o, bus.busy_o);
        end
        rst = 1'b0;
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, e, r, bo, zo);
        checks++;
        if (r !== 64'h00000000_80000000 || e !== 34) begin
            errors++; $display("FAIL rst_then_minint got=%h edges=%0d exp=%h edges=34", r, e, 64'h80000000);
        end
        drop_start();
    endtask

    task automatic test_random;
        int e; logic [63:0] r; logic bo, zo;
        logic s; logic [31:0] a, b;
        for (int n = 0; n < 40; n++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = $urandom_range(1, 100);
                3:       b = 32'd0 - 32'($urandom_range(1, 100));
                default: b = $urandom;
            endcase
            if (b == 32'd0 && n[0]) b = 32'd1;
            run_div(s, a, b, e, r, bo, zo);
            checks++;
            if (r !== model(s, a, b)) begin
                errors++; $display("FAIL rand_result[%0d] s=%b a=%h b=%h got=%h exp=%h", n, s, a, b, r, model(s, a, b));
            end
            checks++;
            if (e !== ((b == 32'd0) ? 2 : 34)) begin
                errors++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", n, e, (b == 32'd0) ? 2 : 34);
            end
            drop_start();
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i = 32'd0;
        bus.opdata2_i = 32'd0;
        test_reset();
        test_unsigned_basic();
        test_signed();
        test_div_zero();
        test_annul();
        test_end_hold();
        test_reset_mid_on();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
